// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered sync/blank decode.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 784,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 515
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        pix_en,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned    DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]     H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]     V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]     HS_END   = 10'(H_SYNC);
  localparam logic [9:0]     VS_END   = 10'(V_SYNC);
  localparam logic [9:0]     HD_START = 10'(H_DISP_START);
  localparam logic [9:0]     HD_END   = 10'(H_DISP_END);
  localparam logic [9:0]     VD_START = 10'(V_DISP_START);
  localparam logic [9:0]     VD_END   = 10'(V_DISP_END);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          frame_wrap;

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_wrap = (h_nxt == '0) && (v_nxt == '0);

  always_comb begin
    h_nxt = hCount + 10'd1;
    v_nxt = vCount;
    if (hCount == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vCount == V_LAST) ? '0 : vCount + 10'd1;
    end
  end

  // Decode from the next counter values so flags land on the same edge as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      hCount      <= H_LAST;
      vCount      <= V_LAST;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DW'(1);
      pix_en      <= tick;
      line_start  <= tick && (h_nxt == '0);
      frame_start <= tick && frame_wrap;
      if (tick) begin
        hCount <= h_nxt;
        vCount <= v_nxt;
        hSync  <= (h_nxt < HS_END);
        vSync  <= (v_nxt < VS_END);
        bright <= (h_nxt >= HD_START) && (h_nxt < HD_END) &&
                  (v_nxt >= VD_START) && (v_nxt < VD_END);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (tick && frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a scaled raster (40x20 positions, CLK_DIV=4).
// Expected ticks are queued by the stimulus; a negedge monitor pops one per pix_en.
module tb_vga_timing_gen;

  localparam int unsigned CD  = 4;
  localparam int unsigned HT  = 40;
  localparam int unsigned VT  = 20;
  localparam int unsigned HS  = 5;
  localparam int unsigned HDS = 8;
  localparam int unsigned HDE = 36;
  localparam int unsigned VS  = 2;
  localparam int unsigned VDS = 4;
  localparam int unsigned VDE = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  hCount, vCount;
  logic        hSync, vSync, bright, pix_en, line_start, frame_start;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_SYNC(HS), .H_DISP_START(HDS), .H_DISP_END(HDE),
    .V_SYNC(VS), .V_DISP_START(VDS), .V_DISP_END(VDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hCount(hCount), .vCount(vCount),
    .hSync(hSync), .vSync(vSync), .bright(bright), .pix_en(pix_en),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs, vs, br, ls, fs;
    logic [15:0] fc;
  } exp_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] f;  // {hSync, vSync, bright}
  } dir_t;

  // Hand-derived boundary points of the scaled raster.
  dir_t dir_tab [11] = '{
    '{10'd0,  10'd0,  3'b110}, '{10'd4,  10'd1,  3'b110}, '{10'd6,  10'd1,  3'b010},
    '{10'd5,  10'd2,  3'b000}, '{10'd7,  10'd4,  3'b000}, '{10'd8,  10'd3,  3'b000},
    '{10'd8,  10'd4,  3'b001}, '{10'd35, 10'd17, 3'b001}, '{10'd36, 10'd17, 3'b000},
    '{10'd35, 10'd18, 3'b000}, '{10'd39, 10'd19, 3'b000}
  };

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   since_rel = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic gen(input int unsigned n, input logic [15:0] fc0);
    int unsigned h = 0;
    int unsigned v = 0;
    logic [15:0] fc = fc0;
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
`ifdef VGA_FRAME_CNT_EN
      if (h == 0 && v == 0) fc = fc + 16'd1;
`endif
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.hs = (h < HS);
      e.vs = (v < VS);
      e.br = (h >= HDS) && (h < HDE) && (v >= VDS) && (v < VDE);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      e.fc = fc;
      sb.push_back(e);
      h++;
      if (h == HT) begin
        h = 0;
        v++;
        if (v == VT) v = 0;
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_hCount"}, 64'(hCount), 64'(HT - 1));
    chk({tag, "_vCount"}, 64'(vCount), 64'(VT - 1));
    chk({tag, "_flags"}, 64'({hSync, vSync, bright, pix_en, line_start, frame_start}), 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({tag, "_div_cnt"}, 64'(dut.div_cnt), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    since_rel <= rst_n ? since_rel + 1 : 0;
  end

  // Monitor: scoreboard compare on pix_en, idle/hold checks otherwise.
  logic        have_pix = 1'b0, have_prev = 1'b0, have_fs = 1'b0;
  int          last_pix = 0, last_fs = 0, bright_cnt = 0;
  logic [22:0] prev_hold;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_pix   = 1'b0;
      have_prev  = 1'b0;
      have_fs    = 1'b0;
      bright_cnt = 0;
    end else if (pix_en) begin
      if (!have_pix) chk("first_tick_edges", 64'(since_rel), 64'(CD));
      else           chk("pixel_period", 64'(cyc - last_pix), 64'(CD));
      have_pix = 1'b1;
      last_pix = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_pix_en", 64'({hCount, vCount}), 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("tick_vector",
            64'({hCount, vCount, hSync, vSync, bright, line_start, frame_start, frame_count}),
            64'(e_mon));
      end
      foreach (dir_tab[i])
        if (hCount == dir_tab[i].h && vCount == dir_tab[i].v)
          chk("boundary_point", 64'({hCount, vCount, hSync, vSync, bright}),
              64'({dir_tab[i].h, dir_tab[i].v, dir_tab[i].f}));
      if (frame_start) begin
        if (have_fs) begin
          chk("frame_period", 64'(cyc - last_fs), 64'(HT * VT * CD));
          chk("bright_per_frame", 64'(bright_cnt), 64'((HDE - HDS) * (VDE - VDS)));
        end
        have_fs    = 1'b1;
        last_fs    = cyc;
        bright_cnt = 0;
      end
      if (bright) bright_cnt++;
      prev_hold = {hCount, vCount, hSync, vSync, bright};
      have_prev = 1'b1;
    end else begin
      chk("strobe_idle", 64'({line_start, frame_start}), 64'd0);
      if (have_prev) chk("hold_between_ticks", 64'({hCount, vCount, hSync, vSync, bright}), 64'(prev_hold));
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_checks("reset");

    // Three full frames, then run into frame 4 up to position (20,10).
    gen(3 * HT * VT + 10 * HT + 21, 16'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain("drain_run1");

    // Asynchronous reset mid-frame, between clock edges.
    chk("pre_reset_pos", 64'({hCount, vCount}), 64'({10'd20, 10'd10}));
    rst_n = 1'b0;
    #1 reset_checks("async_reset");
    repeat (2) @(posedge clk);
    #2 reset_checks("reset_hold");

`ifdef VGA_FRAME_CNT_EN
    gen(2 * HT * VT + 1, 16'hFFFF);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
`else
    gen(2 * HT * VT + 1, 16'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
`endif
    drain("drain_run2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
